tape_head: RTL and testbench



---
 rtl/tape_head_pkg.sv | 35 +++
 rtl/tape_head_tape_mem.sv | 28 ++
 rtl/tape_head.sv | 134 +++++++++++++
 tb/tb_tape_head.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/tape_head_pkg.sv
// Shared constants, symbol encodings and FSM state type for the tape-and-head engine.
package tape_head_pkg;

    localparam logic [7:0] STATE_A    = 8'h01;
    localparam logic [7:0] STATE_B    = 8'h02;
    localparam logic [7:0] STATE_C    = 8'h04;
    localparam logic [7:0] STATE_D    = 8'h08;
    localparam logic [7:0] STATE_E    = 8'h10;
    localparam logic [7:0] STATE_F    = 8'h20;
    localparam logic [7:0] STATE_G    = 8'h40;
    localparam logic [7:0] STATE_H    = 8'h80;
    localparam logic [7:0] STATE_HALT = 8'h00;

    localparam logic [2:0] SYM_000 = 3'b000;
    localparam logic [2:0] SYM_001 = 3'b001;
    localparam logic [2:0] SYM_010 = 3'b010;
    localparam logic [2:0] SYM_100 = 3'b100;
    localparam logic [2:0] SYM_101 = 3'b101;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        FSM_IDLE,
        FSM_FETCH,
        FSM_COMMIT,
        FSM_DONE
    } fsm_e;

    // Exactly one bit set; the zero vector (halt) is excluded.
    function automatic logic is_one_hot(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'd1)) == 8'h00);
    endfunction

endpackage

// File: rtl/tape_head_tape_mem.sv
// Tape storage: DEPTH x 3-bit register file, one write port, one asynchronous read port.
module tape_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [2:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [2:0]    o_rdata
);

    logic [2:0] r_cells [DEPTH];

    // NOTE: the tape must be cleared by reset, so it is built from resettable flops rather than an inferred RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_cells[i] <= 3'b000;
        end else if (i_we) begin
            r_cells[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_cells[i_raddr];

endmodule

// File: rtl/tape_head.sv
// Turing-machine step engine: fetches the symbol under the head, then commits write/move/state
// answers from the combinational rule blocks, flagging halt and faults.
module tape_head
    import tape_head_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int HEAD_INIT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [2:0]    load_sym,
    input  logic          start,
    input  logic [7:0]    next_state,
    input  logic [2:0]    write_sym,
    input  logic          direction,
    output logic [7:0]    state,
    output logic          s2,
    output logic          s1,
    output logic          s0,
    output logic [AW-1:0] head,
    output logic          busy,
    output logic          halted,
    output logic          fault,
    output logic [15:0]   steps
);

    localparam logic [AW-1:0] HEAD_RST = AW'(HEAD_INIT);
    localparam logic [AW-1:0] HEAD_MAX = AW'(DEPTH - 1);

    fsm_e          r_fsm, w_fsm_nxt;
    logic [7:0]    r_state;
    logic [AW-1:0] r_head;
    logic [2:0]    r_sym;
    logic          r_halted, r_fault;
    logic [15:0]   r_steps;

    logic          w_idle_like, w_load, w_commit, w_restart, w_set_halt, w_set_fault, w_at_edge;
    logic [2:0]    w_rd_sym;

    assign w_idle_like = (r_fsm == FSM_IDLE) || (r_fsm == FSM_DONE);
    assign w_load      = load_en && w_idle_like;
    assign w_at_edge   = ((direction == DIR_LEFT)  && (r_head == '0)) ||
                         ((direction == DIR_RIGHT) && (r_head == HEAD_MAX));

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_commit    = 1'b0;
        w_restart   = 1'b0;
        w_set_halt  = 1'b0;
        w_set_fault = 1'b0;
        case (r_fsm)
            FSM_IDLE: if (start) w_fsm_nxt = FSM_FETCH;
            FSM_DONE: begin
                if (start) begin
                    w_fsm_nxt = FSM_FETCH;
                    w_restart = 1'b1;
                end
            end
            FSM_FETCH: w_fsm_nxt = FSM_COMMIT;
            FSM_COMMIT: begin
                w_fsm_nxt = FSM_DONE;
                if (next_state == STATE_HALT) begin
                    w_set_halt = 1'b1;
                end else if (!is_one_hot(next_state) || w_at_edge) begin
                    w_set_fault = 1'b1;
                end else begin
                    w_commit  = 1'b1;
                    w_fsm_nxt = FSM_FETCH;
                end
            end
            default: w_fsm_nxt = FSM_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fsm <= FSM_IDLE;
        else        r_fsm <= w_fsm_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= STATE_A;
            r_head   <= HEAD_RST;
            r_sym    <= SYM_000;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
            r_steps  <= 16'h0000;
        end else begin
            if (w_restart) begin
                r_state  <= STATE_A;
                r_head   <= HEAD_RST;
                r_halted <= 1'b0;
                r_fault  <= 1'b0;
                r_steps  <= 16'h0000;
            end
            if (r_fsm == FSM_FETCH) r_sym <= w_rd_sym;
            if (w_set_halt)  r_halted <= 1'b1;
            if (w_set_fault) r_fault  <= 1'b1;
            if (w_commit) begin
                r_state <= next_state;
                r_head  <= (direction == DIR_RIGHT) ? r_head + 1'b1 : r_head - 1'b1;
                if (r_steps != 16'hFFFF) r_steps <= r_steps + 16'd1;
            end
        end
    end

    // Load and commit writes are mutually exclusive by FSM state, so the commit side takes priority freely.
    tape_mem #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_tape_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_load || w_commit),
        .i_waddr(w_commit ? r_head : load_addr),
        .i_wdata(w_commit ? write_sym : load_sym),
        .i_raddr(r_head),
        .o_rdata(w_rd_sym)
    );

    assign state          = r_state;
    assign {s2, s1, s0}   = r_sym;
    assign head           = r_head;
    assign busy           = (r_fsm == FSM_FETCH) || (r_fsm == FSM_COMMIT);
    assign halted         = r_halted;
    assign fault          = r_fault;
    assign steps          = r_steps;

endmodule

// File: tb/tb_tape_head.sv
// Self-checking bench for tape_head: directed scenarios plus random programs against a step-level model.
module tb_tape_head;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en, start, direction;
    logic [3:0]  load_addr;
    logic [2:0]  load_sym, write_sym;
    logic [7:0]  next_state, state;
    logic        s2, s1, s0, busy, halted, fault;
    logic [3:0]  head;
    logic [15:0] steps;

    always #5 clk = ~clk;

    tape_head #(.DEPTH(16), .AW(4), .HEAD_INIT(8)) dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr), .load_sym(load_sym),
        .start(start), .next_state(next_state), .write_sym(write_sym), .direction(direction),
        .state(state), .s2(s2), .s1(s1), .s0(s0), .head(head), .busy(busy),
        .halted(halted), .fault(fault), .steps(steps)
    );

    // Machine-level reference: tape contents, head index, state, flags, step count.
    logic [2:0] m_tape [16];
    int         m_head;
    logic [7:0] m_state;
    int         m_steps;
    bit         m_halted, m_fault, m_busy;
    logic [2:0] m_sym;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"},  32'(state),          32'(m_state));
        check({tag, ".head"},   32'(head),           32'(m_head));
        check({tag, ".sym"},    32'({s2, s1, s0}),   32'(m_sym));
        check({tag, ".busy"},   32'(busy),           32'(m_busy));
        check({tag, ".halted"}, 32'(halted),         32'(m_halted));
        check({tag, ".fault"},  32'(fault),          32'(m_fault));
        check({tag, ".steps"},  32'(steps),          32'(m_steps));
    endtask

    task automatic model_reset();
        foreach (m_tape[i]) m_tape[i] = 3'b000;
        m_head = 8; m_state = 8'h01; m_steps = 0;
        m_halted = 0; m_fault = 0; m_busy = 0; m_sym = 3'b000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise_on();
        load_en = 1'($urandom); start = 1'($urandom);
        load_addr = 4'($urandom); load_sym = 3'($urandom);
    endtask

    task automatic noise_off();
        load_en = 1'b0; start = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] a, input logic [2:0] s);
        load_en = 1'b1; load_addr = a; load_sym = s;
        tick();
        load_en = 1'b0;
        m_tape[a] = s;
        check_all("load");
    endtask

    task automatic do_start(input bit with_load, input logic [3:0] a, input logic [2:0] s);
        start = 1'b1; load_en = with_load; load_addr = a; load_sym = s;
        tick();
        noise_off();
        if (with_load) m_tape[a] = s;
        m_state = 8'h01; m_head = 8; m_steps = 0;
        m_halted = 0; m_fault = 0; m_busy = 1;
        check_all("start");
    endtask

    // From FETCH: one fetch cycle, then one commit cycle with the given rule answer.
    task automatic do_step(input logic [7:0] ns, input logic [2:0] ws, input bit dir, output bit done);
        int nh;
        noise_on();
        tick();
        noise_off();
        m_sym = m_tape[m_head];
        check_all("fetch");
        next_state = ns; write_sym = ws; direction = dir;
        noise_on();
        tick();
        noise_off();
        done = 1;
        nh = dir ? m_head + 1 : m_head - 1;
        if (ns == 8'h00) begin
            m_halted = 1; m_busy = 0;
        end else if ($countones(ns) != 1 || nh < 0 || nh > 15) begin
            m_fault = 1; m_busy = 0;
        end else begin
            m_tape[m_head] = ws;
            m_state = ns;
            m_head = nh;
            if (m_steps < 65535) m_steps++;
            done = 0;
        end
        check_all("commit");
    endtask

    function automatic logic [7:0] rand_one_hot();
        return 8'h01 << $urandom_range(7, 0);
    endfunction

    function automatic logic [7:0] rand_multi_hot();
        int a, b;
        a = $urandom_range(7, 0);
        b = (a + $urandom_range(7, 1)) % 8;
        return (8'h01 << a) | (8'h01 << b);
    endfunction

    initial begin
        bit d;
        rst_n = 1'b0; load_en = 0; start = 0; load_addr = 0; load_sym = 0;
        next_state = 0; write_sym = 0; direction = 0;
        model_reset();
        tick(); tick();
        check_all("reset");
        @(negedge clk) rst_n = 1'b1;

        // Basic step, continue, halt on the third commit, then restart keeps the tape.
        do_load(4'd8, 3'b001);
        do_start(0, 4'd0, 3'b000);
        do_step(8'h02, 3'b100, 1'b1, d);
        do_step(8'h04, 3'b010, 1'b0, d);
        do_step(8'h00, 3'b111, 1'b1, d);
        do_start(0, 4'd0, 3'b000);

        // Illegal multi-hot next state: nothing committed.
        do_step(8'h05, 3'b111, 1'b1, d);
        do_start(0, 4'd0, 3'b000);
        do_step(8'h00, 3'b000, 1'b0, d);

        // Load and start in the same cycle: the first fetch sees the loaded symbol.
        do_start(1, 4'd8, 3'b101);
        do_step(8'h00, 3'b000, 1'b0, d);

        // Walk to the left edge and try to step off it.
        do_start(0, 4'd0, 3'b000);
        for (int i = 0; i < 8; i++) do_step(rand_one_hot(), 3'($urandom), 1'b0, d);
        do_step(8'h04, 3'b010, 1'b0, d);

        // Walk to the right edge and try to step off it.
        do_start(0, 4'd0, 3'b000);
        for (int i = 0; i < 7; i++) do_step(rand_one_hot(), 3'($urandom), 1'b1, d);
        do_step(8'h08, 3'b001, 1'b1, d);

        // Reset asserted during the third commit.
        do_start(0, 4'd0, 3'b000);
        do_step(8'h02, 3'b101, 1'b1, d);
        do_step(8'h04, 3'b010, 1'b1, d);
        tick();
        m_sym = m_tape[m_head];
        check_all("pre_rst");
        next_state = 8'h08; write_sym = 3'b111; direction = 1'b1;
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        @(negedge clk) rst_n = 1'b1;

        // Read every cell back after reset: right across 8..15, then left across 8..0.
        do_start(0, 4'd0, 3'b000);
        for (int i = 0; i < 8; i++) do_step(8'h02, 3'b000, 1'b1, d);
        do_start(0, 4'd0, 3'b000);
        for (int i = 0; i < 9; i++) do_step(8'h02, 3'b000, 1'b0, d);

        // Random programs.
        for (int run = 0; run < 40; run++) begin
            int nl;
            nl = $urandom_range(3, 0);
            for (int i = 0; i < nl; i++) do_load(4'($urandom), 3'($urandom));
            do_start(1'($urandom), 4'($urandom), 3'($urandom));
            d = 0;
            for (int s = 0; s < 40 && !d; s++) begin
                int r;
                logic [7:0] ns;
                r = $urandom_range(19, 0);
                ns = (r == 0) ? 8'h00 : (r == 1) ? rand_multi_hot() : rand_one_hot();
                do_step(ns, 3'($urandom), 1'($urandom), d);
            end
            if (!d) do_step(8'h00, 3'b000, 1'b0, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
